// File: rtl/tsconf_video_pkg.sv
// Shared video-path constants for the scan-doubler line buffer.
// Holds the line geometry, the nibble-select encoding and the line-phase state type.
package tsconf_video_pkg;

  localparam int LINE_W = 9;
  localparam int DATA_W = 8;

  localparam logic SEL_HI = 1'b0;
  localparam logic SEL_LO = 1'b1;

  typedef enum logic {
    PH_EVEN = 1'b0,
    PH_ODD  = 1'b1
  } line_ph_t;

endpackage

// File: rtl/vga_line_dbl_if.sv
// Strobe, data and status bundle between the video timing logic and the scan doubler.
interface vga_line_dbl_if #(
  parameter int DATA_W = tsconf_video_pkg::DATA_W
);
  logic              c3;
  logic              f0;
  logic              tv_line_start;
  logic              vga_line_start;
  logic              tv_blank;
  logic              vga_blank;
  logic              vga_hires;
  logic [DATA_W-1:0] vplex_in;
  logic [DATA_W-1:0] vgaplex;
  logic              vga_plex_sel;
  logic              vga_line_odd;
  logic              ovf;

  modport master (
    output c3, f0, tv_line_start, vga_line_start, tv_blank, vga_blank, vga_hires, vplex_in,
    input  vgaplex, vga_plex_sel, vga_line_odd, ovf
  );

  modport slave (
    input  c3, f0, tv_line_start, vga_line_start, tv_blank, vga_blank, vga_hires, vplex_in,
    output vgaplex, vga_plex_sel, vga_line_odd, ovf
  );
endinterface

// File: rtl/dpram.sv
// Simple dual-port RAM: port a writes, port b is a registered read with enable.
module dpram #(
  parameter int DATAWIDTH = 8,
  parameter int ADDRWIDTH = 10
) (
  input  logic                 clock,
  input  logic [ADDRWIDTH-1:0] address_a,
  input  logic [DATAWIDTH-1:0] data_a,
  input  logic                 wren_a,
  input  logic [ADDRWIDTH-1:0] address_b,
  input  logic                 rden_b,
  output logic [DATAWIDTH-1:0] q_b
);

  logic [DATAWIDTH-1:0] mem [2**ADDRWIDTH];

  always_ff @(posedge clock) begin
    if (wren_a) mem[address_a] <= data_a;
    if (rden_b) q_b <= mem[address_b];
  end

endmodule

// File: rtl/vga_line_dbl.sv
// Scan doubler: captures a TV-rate line into a ping-pong buffer and replays it twice at VGA rate.
//   state   | meaning
//   PH_EVEN | first replay of the completed TV line (vga_line_odd=0)
//   PH_ODD  | second replay, same bank as PH_EVEN (vga_line_odd=1)
module vga_line_dbl #(
  parameter int LINE_W = tsconf_video_pkg::LINE_W,
  parameter int DATA_W = tsconf_video_pkg::DATA_W
) (
  input logic          clk,
  input logic          rst,
  vga_line_dbl_if.slave vif
);
  import tsconf_video_pkg::*;

  localparam logic [LINE_W-1:0] PTR_MAX = '1;

  logic              wr_bank;
  logic [LINE_W-1:0] wr_ptr;
  logic              ovf_q;
  logic              wr_bank_eff;
  logic [LINE_W-1:0] wr_addr;
  logic              wr_en;

  line_ph_t          line_ph, ph_d;
  logic              resync_pend, resync_d;
  logic              rd_bank, rd_bank_d;

  logic [LINE_W-1:0] rd_ptr, ptr_base;
  logic              rd_phase, phase_base;
  logic              sel_q;
  logic              plex_ok;
  logic              rd_go, fetch;
  logic [DATA_W-1:0] q_b;

  // A line start in the same clk as c3 already targets address 0 of the new bank.
  assign wr_bank_eff = vif.tv_line_start ? ~wr_bank : wr_bank;
  assign wr_addr     = vif.tv_line_start ? '0 : wr_ptr;
  assign wr_en       = vif.c3 & ~vif.tv_blank & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank <= 1'b0;
      wr_ptr  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wr_bank <= wr_bank_eff;
      wr_ptr  <= (wr_en && wr_addr != PTR_MAX) ? wr_addr + 1'b1 : wr_addr;
      if (wr_en && wr_addr == PTR_MAX) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      line_ph     <= PH_EVEN;
      resync_pend <= 1'b0;
      rd_bank     <= 1'b1;
    end else begin
      line_ph     <= ph_d;
      resync_pend <= resync_d;
      rd_bank     <= rd_bank_d;
    end
  end

  always_comb begin
    ph_d      = line_ph;
    resync_d  = resync_pend;
    rd_bank_d = rd_bank;
    if (vif.vga_line_start) begin
      resync_d = 1'b0;
      if (resync_pend || line_ph == PH_ODD) begin
        ph_d      = PH_EVEN;
        rd_bank_d = ~wr_bank;
      end else begin
        ph_d = PH_ODD;
      end
    end
    if (vif.tv_line_start) resync_d = 1'b1;
  end

  // rd_phase is the nibble the next strobe consumes; sel_q is the nibble now on vgaplex.
  assign ptr_base   = vif.vga_line_start ? '0 : rd_ptr;
  assign phase_base = vif.vga_line_start ? SEL_HI : rd_phase;
  assign rd_go      = vif.f0 & ~vif.vga_blank;
  assign fetch      = rd_go & (~vif.vga_hires | (phase_base == SEL_HI));

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      rd_phase <= SEL_HI;
      sel_q    <= SEL_HI;
      plex_ok  <= 1'b0;
    end else begin
      rd_ptr   <= ptr_base;
      rd_phase <= phase_base;
      if (vif.vga_line_start) sel_q <= SEL_HI;
      if (rd_go) begin
        if (!vif.vga_hires) begin
          rd_ptr <= ptr_base + 1'b1;
          sel_q  <= SEL_HI;
        end else begin
          sel_q    <= phase_base;
          rd_phase <= ~phase_base;
          if (phase_base == SEL_LO) rd_ptr <= ptr_base + 1'b1;
        end
      end
      if (fetch) plex_ok <= 1'b1;
    end
  end

  dpram #(
    .DATAWIDTH(DATA_W),
    .ADDRWIDTH(LINE_W + 1)
  ) u_mem (
    .clock    (clk),
    .address_a({wr_bank_eff, wr_addr}),
    .data_a   (vif.vplex_in),
    .wren_a   (wr_en),
    .address_b({rd_bank_d, ptr_base}),
    .rden_b   (fetch & ~rst),
    .q_b      (q_b)
  );

  // The RAM output register is the vgaplex register; plex_ok gives it a reset value.
  assign vif.vgaplex      = plex_ok ? q_b : '0;
  assign vif.vga_plex_sel = sel_q;
  assign vif.vga_line_odd = (line_ph == PH_ODD);
  assign vif.ovf          = ovf_q;

endmodule

// File: tb/tb_vga_line_dbl.sv
// Directed bench for the scan-doubler line buffer with hand-computed expectations.
module tb_vga_line_dbl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  vga_line_dbl_if vif ();

  vga_line_dbl dut (
    .clk(clk),
    .rst(rst),
    .vif(vif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Drive one clk worth of strobes, then land 1 time unit after the active edge.
  task automatic step(input logic c3_i, input logic f0_i, input logic tls_i,
                      input logic vls_i, input logic [7:0] d);
    @(negedge clk);
    vif.c3             = c3_i;
    vif.f0             = f0_i;
    vif.tv_line_start  = tls_i;
    vif.vga_line_start = vls_i;
    vif.vplex_in       = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vif.c3 = 1'b0; vif.f0 = 1'b0; vif.tv_line_start = 1'b0; vif.vga_line_start = 1'b0;
    vif.tv_blank = 1'b0; vif.vga_blank = 1'b0; vif.vga_hires = 1'b0; vif.vplex_in = 8'h00;

    step(0, 0, 0, 0, 8'h00);
    step(0, 0, 0, 0, 8'h00);
    rst = 1'b0;
    chk("rst_plex", 32'(vif.vgaplex), 32'h0);
    chk("rst_sel",  32'(vif.vga_plex_sel), 32'h0);
    chk("rst_odd",  32'(vif.vga_line_odd), 32'h0);
    chk("rst_ovf",  32'(vif.ovf), 32'h0);

    // Lores: fill bank 0 with 0x00..0x0F, replay twice
    for (int i = 0; i < 16; i++) step(1, 0, 0, 0, 8'(i));
    step(0, 0, 1, 0, 8'h00);
    step(0, 0, 0, 1, 8'h00);
    chk("lo1_odd", 32'(vif.vga_line_odd), 32'h0);
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 0, 0, 8'h00);
      chk("lo1_plex", 32'(vif.vgaplex), 32'(i));
      step(0, 0, 0, 0, 8'h00);
    end
    step(0, 0, 0, 1, 8'h00);
    chk("lo2_odd", 32'(vif.vga_line_odd), 32'h1);
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 0, 0, 8'h00);
      chk("lo2_plex", 32'(vif.vgaplex), 32'(i));
    end
    vif.vga_blank = 1'b1;
    step(0, 1, 0, 0, 8'h00);
    chk("blank_hold", 32'(vif.vgaplex), 32'h0F);
    vif.vga_blank = 1'b0;

    // Hires: bank 1 gets 0xA5, 0x3C
    step(1, 0, 0, 0, 8'hA5);
    step(1, 0, 0, 0, 8'h3C);
    step(0, 0, 1, 0, 8'h00);
    vif.vga_hires = 1'b1;
    step(0, 0, 0, 1, 8'h00);
    chk("hi_odd", 32'(vif.vga_line_odd), 32'h0);
    step(0, 1, 0, 0, 8'h00);
    chk("hi_p0", 32'(vif.vgaplex), 32'hA5); chk("hi_s0", 32'(vif.vga_plex_sel), 32'h0);
    step(0, 1, 0, 0, 8'h00);
    chk("hi_p1", 32'(vif.vgaplex), 32'hA5); chk("hi_s1", 32'(vif.vga_plex_sel), 32'h1);
    step(0, 1, 0, 0, 8'h00);
    chk("hi_p2", 32'(vif.vgaplex), 32'h3C); chk("hi_s2", 32'(vif.vga_plex_sel), 32'h0);
    step(0, 1, 0, 0, 8'h00);
    chk("hi_p3", 32'(vif.vgaplex), 32'h3C); chk("hi_s3", 32'(vif.vga_plex_sel), 32'h1);

    // vga_line_start with f0 in the same clk, hires then lores
    step(0, 1, 0, 1, 8'h00);
    chk("hls_plex", 32'(vif.vgaplex), 32'hA5); chk("hls_sel", 32'(vif.vga_plex_sel), 32'h0);
    chk("hls_odd", 32'(vif.vga_line_odd), 32'h1);
    step(0, 1, 0, 0, 8'h00);
    chk("hls_sel2", 32'(vif.vga_plex_sel), 32'h1);
    vif.vga_hires = 1'b0;
    step(0, 1, 0, 1, 8'h00);
    chk("lls_plex", 32'(vif.vgaplex), 32'hA5); chk("lls_odd", 32'(vif.vga_line_odd), 32'h0);
    step(0, 1, 0, 0, 8'h00);
    chk("lls_next", 32'(vif.vgaplex), 32'h3C);

    // tv_line_start with c3 in the same clk
    step(1, 0, 1, 0, 8'h77);
    step(1, 0, 0, 0, 8'h88);
    step(0, 0, 1, 0, 8'h00);
    step(0, 0, 0, 1, 8'h00);
    step(0, 1, 0, 0, 8'h00);
    chk("same_a0", 32'(vif.vgaplex), 32'h77);
    step(0, 1, 0, 0, 8'h00);
    chk("same_a1", 32'(vif.vgaplex), 32'h88);

    // Extra TV line between replays forces a resync
    step(1, 0, 0, 0, 8'h11);
    step(1, 0, 0, 0, 8'h22);
    step(0, 0, 1, 0, 8'h00);
    step(0, 0, 0, 1, 8'h00);
    chk("rsy_odd", 32'(vif.vga_line_odd), 32'h0);
    step(0, 1, 0, 0, 8'h00);
    chk("rsy_a0", 32'(vif.vgaplex), 32'h11);
    step(0, 1, 0, 0, 8'h00);
    chk("rsy_a1", 32'(vif.vgaplex), 32'h22);

    // Overflow: 515 writes into one line, last byte 0xE3
    chk("ovf_pre", 32'(vif.ovf), 32'h0);
    for (int i = 0; i < 515; i++) step(1, 0, 0, 0, (i == 514) ? 8'hE3 : 8'(i));
    chk("ovf_set", 32'(vif.ovf), 32'h1);
    step(0, 0, 1, 0, 8'h00);
    step(0, 0, 0, 1, 8'h00);
    for (int i = 0; i < 512; i++) begin
      step(0, 1, 0, 0, 8'h00);
      if (i == 0)   chk("ovf_a0",   32'(vif.vgaplex), 32'h00);
      if (i == 510) chk("ovf_a510", 32'(vif.vgaplex), 32'hFE);
      if (i == 511) chk("ovf_last", 32'(vif.vgaplex), 32'hE3);
    end
    chk("ovf_stick", 32'(vif.ovf), 32'h1);
    step(0, 1, 0, 0, 8'h00);
    chk("wrap_a0", 32'(vif.vgaplex), 32'h00);
    step(0, 1, 0, 0, 8'h00);
    chk("wrap_a1", 32'(vif.vgaplex), 32'h01);

    // Reset mid-line with f0 active
    vif.vga_hires = 1'b1;
    step(0, 0, 0, 1, 8'h00);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 8'h00);
    chk("pre_plex", 32'(vif.vgaplex), 32'h01);
    chk("pre_sel",  32'(vif.vga_plex_sel), 32'h1);
    chk("pre_odd",  32'(vif.vga_line_odd), 32'h1);
    chk("pre_ptr",  32'(dut.rd_ptr), 32'h2);
    rst = 1'b1;
    step(0, 1, 0, 0, 8'h00);
    rst = 1'b0;
    chk("mrst_plex", 32'(vif.vgaplex), 32'h0);
    chk("mrst_sel",  32'(vif.vga_plex_sel), 32'h0);
    chk("mrst_odd",  32'(vif.vga_line_odd), 32'h0);
    chk("mrst_ptr",  32'(dut.rd_ptr), 32'h0);
    chk("mrst_ovf",  32'(vif.ovf), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
